slc3_input_conditioner: RTL
===========================

Name: slc3_input_conditioner

Overview:
- Board-facing front end that sits directly upstream of the SLC-3 top level.
- Takes raw active-low pushbuttons and slide switches, synchronises them into Clk and debounces them.
- Produces clean levels plus one-cycle press/release strobes.
- These outputs drive the CPU's Run/Continue controls and the SW bus consumed by the memory-mapped I/O.

Parameters:
- NUM_KEYS, 2, number of pushbutton channels (bit 0 = Run, bit 1 = Continue by board convention).
- SW_WIDTH, 10, number of slide-switch channels.
- DEBOUNCE_CYCLES, 50000, stable-input cycles required before a level change is accepted (1 ms at 50 MHz); legal range >= 1.
- REPEAT_DELAY, 25000000, cycles held before the first auto-repeat strobe (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between later auto-repeat strobes (used only with AUTO_REPEAT_EN).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- KEY_N  in  NUM_KEYS  raw pushbuttons, active-low, asynchronous to Clk.
- SW_In  in  SW_WIDTH  raw slide switches, active-high, asynchronous.
- Key_Level  out  NUM_KEYS  debounced key state, 1 = pressed.
- Key_Press  out  NUM_KEYS  one-cycle strobe on accepted press (or auto-repeat).
- Key_Release  out  NUM_KEYS  one-cycle strobe on accepted release.
- SW_Out  out  SW_WIDTH  debounced switch levels.

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-high.
- Every channel (each key and each switch bit) is independent.
- Synchroniser: 2-flop chain per channel. Key inputs are inverted before the chain, so raw = 1 means pressed. Sync flops reset to 0.
- Per-channel FSM states:
  - STABLE_LO: raw=1 -> CHK_HI, cnt<=0.
  - CHK_HI: raw=0 -> STABLE_LO (bounce rejected, no strobe). cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, Level<=1. Otherwise cnt<=cnt+1.
  - STABLE_HI: raw=0 -> CHK_LO, cnt<=0.
  - CHK_LO: the symmetric case. Reaching the end leads to STABLE_LO with Level<=0.
- Counter: width $clog2(DEBOUNCE_CYCLES+1), no wrap. The counter is compared, never overflowed.
- Latency: on a clean pin change first sampled at edge 0, Level changes at edge DEBOUNCE_CYCLES+2.
- Key_Press is high for exactly the first cycle in which Key_Level is 1. Key_Release is high for exactly the first cycle in which Key_Level is 0 after having been 1. Both strobes are registered, with no combinational path from pins.
- A glitch shorter than DEBOUNCE_CYCLES+1 synchronised cycles never changes Level or emits a strobe. It only restarts the check.
- Press and Release can never be high on the same cycle for the same channel. Different channels may strobe on the same cycle.
- Reset values: all FSMs in STABLE_LO, cnt=0, Key_Level=0, Key_Press=0, Key_Release=0, SW_Out=0.
- Reset asserted mid-check: the channel returns to STABLE_LO immediately and emits no strobe.
- Key held through reset release: it is treated as a new press, and Key_Press fires at edge DEBOUNCE_CYCLES+2 after the first post-reset sampling edge.
- Switches use the same FSM. Their strobes are generated internally but left unconnected.

Optional Feature:
- Macro: SLC3_INPUT_AUTO_REPEAT_EN.
- Defined: each key channel in STABLE_HI runs a repeat counter. Key_Press re-fires after REPEAT_DELAY cycles of continuous hold, then every REPEAT_PERIOD cycles until the state leaves STABLE_HI. Leaving STABLE_HI clears the repeat counter. Switch channels never repeat.
- Undefined: exactly one Key_Press per accepted press, and the repeat logic is absent from the netlist.

Decomposition:
- Package slc3_input_pkg holds:
  - typedef enum logic [1:0] db_state_t {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO};
  - localparam defaults for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD;
  - a function returning counter width.
- Sub-module db_channel: one synchroniser, FSM and counter, with outputs level/press/release. Instantiated NUM_KEYS+SW_WIDTH times via generate.
- Top: inversion, repeat logic, output wiring.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
1. Clean press: KEY_N[0] 1->0 sampled at edge 0 and held -> Key_Level[0]=1 at edge 6; Key_Press[0] high for one cycle only; Key_Release stays 0.
2. Bounce reject: KEY_N[1] low for 3 cycles, high 2, low held -> no strobe until edge 6 after the final falling sample; exactly one Key_Press[1].
3. Release: from a held state, KEY_N[0] 0->1 -> Key_Level[0]=0 at edge 6; one Key_Release[0] pulse; no Key_Press.
4. Switches: SW_In=10'h2A5 applied -> SW_Out=10'h2A5 at edge 6; a 2-cycle glitch on SW_In[3] leaves SW_Out unchanged.
5. Reset mid-check: assert Reset at edge 3 of a press -> all outputs 0 immediately. Release Reset with the key still held -> one Key_Press 6 edges after the first post-reset sample.
6. With SLC3_INPUT_AUTO_REPEAT_EN: hold KEY_N[1] low for 60 cycles after acceptance -> Key_Press[1] at acceptance, then +20, +28, +36, +44, +52. Without the macro -> a single pulse only.

Source files
------------

// File: rtl/slc3_input_pkg.sv
// slc3_input_pkg: shared debounce FSM states, default timing constants and counter sizing.
package slc3_input_pkg;
  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} db_state_t;
  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int REPEAT_DELAY_DEFAULT = 25000000;
  localparam int REPEAT_PERIOD_DEFAULT = 5000000;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/slc3_input_conditioner_if.sv
// slc3_input_conditioner_if: raw board pins in, debounced levels and strobes out.
interface slc3_input_conditioner_if #(parameter int NUM_KEYS = 2, parameter int SW_WIDTH = 10);
  logic [NUM_KEYS-1:0] KEY_N, Key_Level, Key_Press, Key_Release;
  logic [SW_WIDTH-1:0] SW_In, SW_Out;
  modport master (output KEY_N, SW_In, input Key_Level, Key_Press, Key_Release, SW_Out);
  modport slave (input KEY_N, SW_In, output Key_Level, Key_Press, Key_Release, SW_Out);
endinterface

// File: rtl/db_channel.sv
// db_channel: two-flop synchroniser plus debounce FSM with registered press/release strobes.
module db_channel import slc3_input_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  db_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] sync_q;
  logic press_q, press_d, rel_q, rel_d, raw;
  assign raw = sync_q[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      state_q <= STABLE_LO;
      cnt_q <= '0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      state_q <= state_d;
      cnt_q <= cnt_d;
      press_q <= press_d;
      rel_q <= rel_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    press_d = 1'b0;
    rel_d = 1'b0;
    unique case (state_q)
      STABLE_LO: if (raw) begin state_d = CHK_HI; cnt_d = '0; end
      CHK_HI:
        if (!raw) state_d = STABLE_LO;
        else if (cnt_q == LAST) begin state_d = STABLE_HI; press_d = 1'b1; end
        else cnt_d = cnt_q + 1'b1;
      STABLE_HI: if (!raw) begin state_d = CHK_LO; cnt_d = '0; end
      CHK_LO:
        if (raw) state_d = STABLE_HI;
        else if (cnt_q == LAST) begin state_d = STABLE_LO; rel_d = 1'b1; end
        else cnt_d = cnt_q + 1'b1;
    endcase
  end
  // level is a pure decode of the state register, so it flips on the same edge as the strobes
  assign level = state_q == STABLE_HI || state_q == CHK_LO;
  assign hold = state_q == STABLE_HI;
  assign press = press_q;
  assign rel = rel_q;
endmodule

// File: rtl/slc3_input_conditioner.sv
// slc3_input_conditioner: debounced keys/switches for SLC-3; SLC3_INPUT_AUTO_REPEAT_EN adds key auto-repeat.
module slc3_input_conditioner import slc3_input_pkg::*; #(
  parameter int NUM_KEYS = 2,
  parameter int SW_WIDTH = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
  input logic Clk,
  input logic Reset,
  slc3_input_conditioner_if.slave io
);
  localparam int N = NUM_KEYS + SW_WIDTH;
  logic [N-1:0] din, lv, pr, rl, hd;
  logic unused_sw;
  assign din = {io.SW_In, ~io.KEY_N};
  for (genvar g = 0; g < N; g++) begin : g_ch
    db_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk(Clk), .rst(Reset), .din(din[g]),
      .level(lv[g]), .press(pr[g]), .rel(rl[g]), .hold(hd[g])
    );
  end
  assign io.Key_Level = lv[NUM_KEYS-1:0];
  assign io.Key_Release = rl[NUM_KEYS-1:0];
  assign io.SW_Out = lv[N-1:NUM_KEYS];
  assign unused_sw = ^{pr[N-1:NUM_KEYS], rl[N-1:NUM_KEYS], hd[N-1:NUM_KEYS]};
`ifdef SLC3_INPUT_AUTO_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  logic [NUM_KEYS-1:0][RW-1:0] rpt_q, rpt_d;
  logic [NUM_KEYS-1:0] first_q, first_d, rep_q, rep_d;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      rpt_q <= '0;
      first_q <= '1;
      rep_q <= '0;
    end else begin
      rpt_q <= rpt_d;
      first_q <= first_d;
      rep_q <= rep_d;
    end
  // first_q selects the initial delay; afterwards the counter restarts on each repeat with the period
  always_comb begin
    rpt_d = rpt_q;
    first_d = first_q;
    rep_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      rep_d[k] = hd[k] && rpt_q[k] == (first_q[k] ? DLY_LAST : PER_LAST);
      rpt_d[k] = (!hd[k] || rep_d[k]) ? '0 : rpt_q[k] + 1'b1;
      first_d[k] = !hd[k] || (first_q[k] && !rep_d[k]);
    end
  end
  assign io.Key_Press = pr[NUM_KEYS-1:0] | rep_q;
`else
  localparam int unused_rpt = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_hd;
  assign unused_hd = ^hd[NUM_KEYS-1:0];
  assign io.Key_Press = pr[NUM_KEYS-1:0];
`endif
endmodule
